// File: rtl/cpu_seq_ctrl_if.sv
// Bus, decoder and commit signals between the NPC sequencer and its surroundings.
// Handshakes: req is held until the edge where req && ready, which accepts it; rvalid is a one-cycle strobe sampled only while waiting.
interface cpu_seq_ctrl_if #(
  parameter int INST_W = 32
);
  logic              ifu_req;
  logic              ifu_ready;
  logic              ifu_rvalid;
  logic [INST_W-1:0] ifu_rdata;
  logic [INST_W-1:0] inst_o;
  logic              dec_regwr;
  logic              dec_memtoreg;
  logic              dec_memwr;
  logic [1:0]        dec_csr_ctr;
  logic              dec_halt;
  logic              lsu_req;
  logic              lsu_we;
  logic              lsu_ready;
  logic              lsu_rvalid;
  logic [INST_W-1:0] lsu_rdata;
  logic [INST_W-1:0] load_data;
  logic              pc_we;
  logic              rf_we;
  logic              csr_we;
  logic              retire;
  logic              halted;
  logic              timeout_err;
  logic [3:0]        state_o;

  modport master (
    output ifu_req, inst_o, lsu_req, lsu_we, load_data,
           pc_we, rf_we, csr_we, retire, halted, timeout_err, state_o,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
           dec_regwr, dec_memtoreg, dec_memwr, dec_csr_ctr, dec_halt,
           lsu_ready, lsu_rvalid, lsu_rdata
  );

  modport slave (
    input  ifu_req, inst_o, lsu_req, lsu_we, load_data,
           pc_we, rf_we, csr_we, retire, halted, timeout_err, state_o,
    output ifu_ready, ifu_rvalid, ifu_rdata,
           dec_regwr, dec_memtoreg, dec_memwr, dec_csr_ctr, dec_halt,
           lsu_ready, lsu_rvalid, lsu_rdata
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle NPC sequencer: fetch, decode, optional load/store, write-back commit strobes.
// Bus states are guarded by a wait counter that forces HALT if a handshake never completes.
module cpu_seq_ctrl #(
   parameter int INST_W         = 32,
   parameter int TIMEOUT_W      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   cpu_seq_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      BOOT     = 4'd0,
      IF_REQ   = 4'd1,
      IF_WAIT  = 4'd2,
      DECODE   = 4'd3,
      EXEC     = 4'd4,
      MEM_REQ  = 4'd5,
      MEM_WAIT = 4'd6,
      WB       = 4'd7,
      HALT     = 4'd8
   } state_e;

   localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [TIMEOUT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [INST_W-1:0]     inst_q, inst_d;
   logic [INST_W-1:0]     load_q, load_d;
   logic                  timeout_q, timeout_d;
   logic                  bus_wait;
   logic                  exit_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         wait_cnt_q <= '0;
         inst_q     <= '0;
         load_q     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         inst_q     <= inst_d;
         load_q     <= load_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      load_d    = load_q;
      timeout_d = timeout_q;
      bus_wait  = 1'b0;
      exit_ok   = 1'b0;
      case (state_q)
         BOOT:    state_d = IF_REQ;
         IF_REQ: begin
            bus_wait = 1'b1;
            exit_ok  = bus.ifu_ready;
            if (exit_ok) state_d = IF_WAIT;
         end
         IF_WAIT: begin
            bus_wait = 1'b1;
            exit_ok  = bus.ifu_rvalid;
            if (exit_ok) begin
               inst_d  = bus.ifu_rdata;
               state_d = DECODE;
            end
         end
         DECODE:  state_d = EXEC;
         EXEC:    state_d = (bus.dec_memtoreg || bus.dec_memwr) ? MEM_REQ : WB;
         MEM_REQ: begin
            bus_wait = 1'b1;
            exit_ok  = bus.lsu_ready;
            if (exit_ok) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            bus_wait = 1'b1;
            exit_ok  = bus.lsu_rvalid;
            if (exit_ok) begin
               if (!bus.dec_memwr) load_d = bus.lsu_rdata;
               state_d = WB;
            end
         end
         WB:      state_d = bus.dec_halt ? HALT : IF_REQ;
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase

      // A handshake landing on the last allowed cycle still wins.
      if (bus_wait && !exit_ok && (wait_cnt_q == LAST_WAIT)) begin
         state_d   = HALT;
         timeout_d = 1'b1;
      end

      if (state_d != state_q) wait_cnt_d = '0;
      else if (bus_wait)      wait_cnt_d = wait_cnt_q + 1'b1;
      else                    wait_cnt_d = wait_cnt_q;
   end

   assign bus.ifu_req     = (state_q == IF_REQ);
   assign bus.lsu_req     = (state_q == MEM_REQ);
   assign bus.lsu_we      = ((state_q == MEM_REQ) || (state_q == MEM_WAIT)) && bus.dec_memwr;
   assign bus.pc_we       = (state_q == WB);
   assign bus.retire      = (state_q == WB);
   assign bus.rf_we       = (state_q == WB) && bus.dec_regwr && !bus.dec_memwr;
   assign bus.csr_we      = (state_q == WB) && (bus.dec_csr_ctr == 2'b10);
   assign bus.halted      = (state_q == HALT);
   assign bus.timeout_err = timeout_q;
   assign bus.inst_o      = inst_q;
   assign bus.load_data   = load_q;
   assign bus.state_o     = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a monitor pops expected write-back and memory-request
// records from queues as the DUT presents them; stimulus tasks push the hand-computed values.
module tb_cpu_seq_ctrl;
  localparam int W = 67; // {pc_we, rf_we, csr_we, load_data[31:0], inst_o[31:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if #(.INST_W(32)) bus ();

  cpu_seq_ctrl #(.INST_W(32), .TIMEOUT_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [8:0]   exp_mem_q[$]; // {lsu_we, cycles lsu_req was held}
  int req_cycles = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cycles = 0;
    end else begin
      if (bus.retire) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got retire=1 expected no write-back");
        end else begin
          check("wb_record", {bus.pc_we, bus.rf_we, bus.csr_we, bus.load_data, bus.inst_o},
                exp_q.pop_front());
        end
      end else begin
        check("idle_strobes", W'({bus.pc_we, bus.rf_we, bus.csr_we}), '0);
      end
      if (bus.lsu_req) req_cycles++;
      if (bus.lsu_req && bus.lsu_ready) begin
        if (exp_mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got lsu request accepted expected none");
        end else begin
          check("mem_req", W'({bus.lsu_we, 8'(req_cycles)}), W'(exp_mem_q.pop_front()));
        end
        req_cycles = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.ifu_ready = 0; bus.ifu_rvalid = 0; bus.ifu_rdata = '0;
    bus.dec_regwr = 0; bus.dec_memtoreg = 0; bus.dec_memwr = 0;
    bus.dec_csr_ctr = 2'b00; bus.dec_halt = 0;
    bus.lsu_ready = 0; bus.lsu_rvalid = 0; bus.lsu_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("rst_state", W'(bus.state_o), W'(4'd0));
    check("rst_inst", W'(bus.inst_o), '0);
    check("rst_load", W'(bus.load_data), '0);
    check("rst_flags", W'({bus.halted, bus.timeout_err}), '0);
    check("rst_reqs", W'({bus.ifu_req, bus.lsu_req, bus.lsu_we}), '0);
    check("rst_strobes", W'({bus.pc_we, bus.rf_we, bus.csr_we, bus.retire}), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction starting in IF_REQ with a zero-wait fetch port.
  task automatic do_instr(input string name, input logic [31:0] inst,
                          input logic regwr, input logic memtoreg, input logic memwr,
                          input logic [1:0] csr, input logic halt,
                          input int delay, input logic [31:0] rdata,
                          input logic exp_rf, input logic exp_csr, input logic [31:0] exp_ld,
                          input int exp_cyc, input int exp_req);
    int n;
    int mcnt;
    logic [3:0] st;
    bit done;
    bus.dec_regwr = regwr; bus.dec_memtoreg = memtoreg; bus.dec_memwr = memwr;
    bus.dec_csr_ctr = csr; bus.dec_halt = halt;
    bus.ifu_ready = 1; bus.ifu_rvalid = 1; bus.ifu_rdata = inst;
    bus.lsu_ready = 0; bus.lsu_rvalid = 1; bus.lsu_rdata = rdata;
    exp_q.push_back({1'b1, exp_rf, exp_csr, exp_ld, inst});
    if (memtoreg || memwr) exp_mem_q.push_back({memwr, 8'(exp_req)});
    n = 0; mcnt = 0; done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      st = bus.state_o;
      bus.lsu_ready = (st == 4'd5) && (mcnt >= delay);
      if (st == 4'd5) mcnt++;
      if (st == 4'd6) check({name, "_we_wait"}, W'(bus.lsu_we), W'(memwr));
      if (st == 4'd1 || st == 4'd8) done = 1;
    end
    check({name, "_cycles"}, W'(n), W'(exp_cyc));
  endtask

  // ---------------- main sequence ----------------
  int seq [7] = '{0, 1, 2, 3, 4, 7, 1};

  initial begin
    int cnt;
    int k;
    clear_inputs();

    // Reset and a single addi with zero-wait fetch.
    do_reset();
    bus.ifu_ready = 1; bus.ifu_rvalid = 1; bus.ifu_rdata = 32'h0000_0013;
    bus.dec_regwr = 1;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0013});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("state_seq", W'(bus.state_o), W'(seq[i]));
      if (i == 5) check("wb_cycle6", W'({bus.pc_we, bus.rf_we, bus.retire, bus.csr_we}), W'(4'b1110));
    end

    //       name     inst          rw mtr mw csr    halt dly rdata          rf csr ld            cyc req
    do_instr("load",  32'h0000A083, 1, 1,  0, 2'b00, 0,   3,  32'hDEADBEEF,  1, 0,  32'hDEADBEEF, 10, 4);
    do_instr("store", 32'h00112023, 1, 0,  1, 2'b00, 0,   0,  32'h12345678,  0, 0,  32'hDEADBEEF, 7,  1);
    do_instr("csrw",  32'h30529073, 0, 0,  0, 2'b10, 0,   0,  32'h0,         0, 1,  32'hDEADBEEF, 5,  0);
    do_instr("csr11", 32'h3052B073, 1, 0,  0, 2'b11, 0,   0,  32'h0,         1, 0,  32'hDEADBEEF, 5,  0);
    do_instr("load0", 32'h00002003, 0, 1,  0, 2'b00, 0,   0,  32'h0BADF00D,  0, 0,  32'h0BADF00D, 7,  1);
    do_instr("ebrk",  32'h00100073, 0, 0,  0, 2'b00, 1,   0,  32'h0,         0, 0,  32'h0BADF00D, 5,  0);

    check("halt_state", W'(bus.state_o), W'(4'd8));
    check("halt_flag", W'(bus.halted), W'(1'b1));
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ifu_req || bus.lsu_req) cnt++;
    end
    check("halt_no_req", W'(cnt), '0);
    check("halt_sticky", W'({bus.halted, bus.timeout_err}), W'(2'b10));

    // Fetch never accepted: four IF_REQ cycles then timeout.
    do_reset();
    cnt = 0; k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (bus.state_o == 4'd1) cnt++;
      if (bus.state_o == 4'd8) break;
    end
    check("to_ifreq_cycles", W'(cnt), W'(4));
    check("to_state", W'(bus.state_o), W'(4'd8));
    check("to_flags", W'({bus.halted, bus.timeout_err}), W'(2'b11));

    // Fetch accepted in the fourth IF_REQ cycle: handshake beats timeout.
    do_reset();
    cnt = 0; k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (bus.state_o == 4'd1) begin
        cnt++;
        bus.ifu_ready = (cnt == 4);
      end else begin
        bus.ifu_ready = 0;
      end
      if (bus.state_o != 4'd0 && bus.state_o != 4'd1) break;
    end
    check("late_ready_cycles", W'(cnt), W'(4));
    check("late_ready_state", W'(bus.state_o), W'(4'd2));
    check("late_ready_noerr", W'({bus.halted, bus.timeout_err}), '0);
    bus.ifu_rvalid = 1; bus.ifu_rdata = 32'h0050_0093; bus.dec_regwr = 1;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0, 32'h0050_0093});
    k = 0;
    while (k < 10) begin
      @(posedge clk); #1;
      k++;
      if (bus.state_o == 4'd1) break;
    end
    check("late_ready_commit", W'(bus.state_o), W'(4'd1));

    @(negedge clk);
    check("queues_empty", W'(exp_q.size() + exp_mem_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core. It drives instruction fetch and load/store bus handshakes, latches the fetched instruction for the combinational control decoder, and issues single-cycle commit strobes to the PC, register file and CSR file.
- It sits between the IFU/LSU bus ports and the datapath.
- It detects bus hangs with a wait timeout and stops the core on ebreak.

Parameters:
- INST_W, 32, instruction and load-data width.
- TIMEOUT_W, 8, wait-counter width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in any bus state before timeout. Legal range is 2..2^TIMEOUT_W-1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req  out  1  fetch request valid.
- ifu_ready  in  1  fetch request accepted.
- ifu_rvalid  in  1  fetch data valid.
- ifu_rdata  in  INST_W  fetched instruction.
- inst_o  out  INST_W  latched instruction, fed to the decoder.
- dec_regwr  in  1  decoder RegWr.
- dec_memtoreg  in  1  decoder MemtoReg (load).
- dec_memwr  in  1  decoder MemWr (store).
- dec_csr_ctr  in  2  decoder csr_ctr (10 = CSR write).
- dec_halt  in  1  decoded ebreak.
- lsu_req  out  1  memory request valid.
- lsu_we  out  1  store (1) or load (0).
- lsu_ready  in  1  memory request accepted.
- lsu_rvalid  in  1  load data or store acknowledge.
- lsu_rdata  in  INST_W  load data.
- load_data  out  INST_W  latched load data.
- pc_we  out  1  PC update strobe.
- rf_we  out  1  register-file write strobe.
- csr_we  out  1  CSR write strobe.
- retire  out  1  instruction-commit pulse.
- halted  out  1  core stopped (sticky).
- timeout_err  out  1  bus timeout occurred (sticky).
- state_o  out  4  current state, for debug.

Behaviour:
- States and encodings: BOOT=0, IF_REQ=1, IF_WAIT=2, DECODE=3, EXEC=4, MEM_REQ=5, MEM_WAIT=6, WB=7, HALT=8.
- Reset (rst_n low, asynchronous): state=BOOT; inst_o=0; load_data=0; wait_cnt=0; halted=0; timeout_err=0. All strobes and requests are 0 while in reset and in BOOT.
- Outputs are Moore-decoded from state unless stated otherwise:
  - ifu_req=1 only in IF_REQ.
  - lsu_req=1 only in MEM_REQ.
  - lsu_we=dec_memwr in MEM_REQ/MEM_WAIT, else 0.
- BOOT -> IF_REQ unconditionally, one cycle after rst_n rises.
- IF_REQ: exits to IF_WAIT on the edge where ifu_req&ifu_ready. ifu_req stays high until accepted.
- IF_WAIT: on ifu_rvalid, inst_o<=ifu_rdata and state goes to DECODE. An ifu_rvalid outside IF_WAIT is ignored.
- DECODE -> EXEC unconditionally. The dec_* inputs are valid from DECODE onward, because inst_o is held.
- EXEC:
  - if dec_memtoreg|dec_memwr -> MEM_REQ;
  - else -> WB.
- MEM_REQ -> MEM_WAIT on lsu_req&lsu_ready.
- MEM_WAIT: on lsu_rvalid -> WB. If it is a load (dec_memwr=0), load_data<=lsu_rdata in the same edge.
- WB strobes, each exactly one cycle:
  - pc_we=1 and retire=1;
  - rf_we=dec_regwr&~dec_memwr;
  - csr_we=(dec_csr_ctr==2'b10).
- WB exit: if dec_halt -> HALT; else -> IF_REQ. ebreak therefore retires before halting.
- HALT:
  - halted=1;
  - no requests and no strobes;
  - stays in HALT until reset.
- Timeout:
  - wait_cnt clears on every state transition.
  - It increments each cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT.
  - If wait_cnt==TIMEOUT_CYCLES-1 and the state's exit condition is false that cycle -> HALT with timeout_err<=1.
  - A handshake that completes in the same cycle wins over the timeout.
- Latency: minimum 5 cycles per non-memory instruction (IF_REQ, IF_WAIT, DECODE, EXEC, WB) when ready/rvalid are given zero-wait. Memory instructions take a minimum of 7 cycles.
- Reset mid-operation: any outstanding request is abandoned. The bus side must tolerate a dropped req.
- Single outstanding transaction only. No back-to-back pipelining of fetches.

Test Plan:
- Reset release, ifu_ready/ifu_rvalid tied high, inst=0x00000013 (addi), dec_regwr=1:
  - state sequence 0,1,2,3,4,7,1;
  - pc_we, rf_we and retire pulse in cycle 6 after reset;
  - csr_we=0.
- Load: ifu zero-wait, dec_memtoreg=1, lsu_ready delayed 3 cycles, lsu_rvalid with rdata=0xDEADBEEF:
  - lsu_req held high 4 cycles, lsu_we=0;
  - load_data=0xDEADBEEF in WB;
  - rf_we=1.
- Store: dec_memwr=1, dec_regwr=1:
  - lsu_we=1 during MEM_REQ/MEM_WAIT;
  - WB gives pc_we=1, rf_we=0.
- CSR write, dec_csr_ctr=10: csr_we=1 for exactly the one WB cycle. With dec_csr_ctr=11, csr_we=0 and pc_we=1.
- ebreak, dec_halt=1: WB retires (retire=1), then HALT; halted=1 sticky; no further ifu_req over 50 cycles.
- Timeout, TIMEOUT_CYCLES=4, ifu_ready stuck low:
  - HALT after 4 IF_REQ cycles with timeout_err=1.
  - Repeat with ifu_ready rising in the 4th cycle: no timeout, state goes to IF_WAIT.
